// File: rtl/alu_cmd_sequencer.sv
// Front-end command sequencer for the system ALU: collects operand/function bytes,
// issues a one-cycle ALU enable, and returns the 2*DATA_WIDTH result low byte first.
module alu_cmd_sequencer #(
  parameter int unsigned               DATA_WIDTH = 8,
  parameter int unsigned               FUN_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0]     CMD_OP     = 8'hCC,
  parameter logic [DATA_WIDTH-1:0]     CMD_REPEAT = 8'hDD,
  parameter int unsigned               TIMEOUT    = 255
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [DATA_WIDTH-1:0]        RX_P_DATA,
  input  logic                         RX_D_VLD,
  output logic [DATA_WIDTH-1:0]        ALU_A,
  output logic [DATA_WIDTH-1:0]        ALU_B,
  output logic [FUN_WIDTH-1:0]         ALU_FUN,
  output logic                         ALU_EN,
  output logic                         ALU_CLK_EN,
  input  logic [2*DATA_WIDTH-1:0]      ALU_OUT,
  input  logic                         ALU_OUT_VLD,
  output logic [DATA_WIDTH-1:0]        TX_P_DATA,
  output logic                         TX_D_VLD,
  input  logic                         TX_READY,
  output logic                         BUSY,
  output logic                         FRAME_ERR,
  output logic                         FUN_ERR
);

  localparam int unsigned      CntW     = $clog2(TIMEOUT + 1);
  // Last idle count before the abort; a missing byte on this cycle expires the frame.
  localparam logic [CntW-1:0]  CntLast  = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StGetA, StGetB, StGetFun, StAluIssue, StAluWait, StTxLo, StTxHi
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   b_q, b_d;
  logic [FUN_WIDTH-1:0]    fun_q, fun_d;
  logic [2*DATA_WIDTH-1:0] res_q, res_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    frame_err_q, frame_err_d;
  logic                    fun_err_q, fun_err_d;
  logic                    in_get;

  // State, operand, result and error-pulse registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      fun_q       <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
      fun_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      fun_q       <= fun_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      frame_err_q <= frame_err_d;
      fun_err_q   <= fun_err_d;
    end
  end

  assign in_get = (state_q == StGetA) || (state_q == StGetB) || (state_q == StGetFun);

  // Next-state, operand capture and inter-byte timeout.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    fun_d       = fun_q;
    res_d       = res_q;
    cnt_d       = '0;
    frame_err_d = 1'b0;
    fun_err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_OP) begin
            state_d = StGetA;
          end else if (RX_P_DATA == CMD_REPEAT) begin
            state_d = StGetFun;
          end
        end
      end
      StGetA: begin
        if (RX_D_VLD) begin
          a_d     = RX_P_DATA;
          state_d = StGetB;
        end
      end
      StGetB: begin
        if (RX_D_VLD) begin
          b_d     = RX_P_DATA;
          state_d = StGetFun;
        end
      end
      StGetFun: begin
        if (RX_D_VLD) begin
          fun_d   = RX_P_DATA[FUN_WIDTH-1:0];
          state_d = StAluIssue;
        end
      end
      StAluIssue: state_d = StAluWait;
      StAluWait: begin
        if (ALU_OUT_VLD) begin
          res_d   = ALU_OUT;
          state_d = StTxLo;
        end else begin
          fun_err_d = 1'b1;
          state_d   = StIdle;
        end
      end
      StTxLo: if (TX_READY) state_d = StTxHi;
      StTxHi: if (TX_READY) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A byte arriving on the expiry cycle wins: counter clears and the frame continues.
    if (in_get && !RX_D_VLD) begin
      if (cnt_q == CntLast) begin
        state_d     = StIdle;
        frame_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Outputs decoded from the state register and stored data only.
  always_comb begin
    TX_P_DATA = '0;
    if (state_q == StTxLo) begin
      TX_P_DATA = res_q[DATA_WIDTH-1:0];
    end else if (state_q == StTxHi) begin
      TX_P_DATA = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
    end
  end

  assign ALU_A      = a_q;
  assign ALU_B      = b_q;
  assign ALU_FUN    = fun_q;
  assign ALU_EN     = (state_q == StAluIssue);
  assign ALU_CLK_EN = (state_q == StAluIssue) || (state_q == StAluWait);
  assign TX_D_VLD   = (state_q == StTxLo) || (state_q == StTxHi);
  assign BUSY       = (state_q != StIdle);
  assign FRAME_ERR  = frame_err_q;
  assign FUN_ERR    = fun_err_q;

endmodule
